// File: rtl/plugboard_load_seq_if.sv
// rtl/plugboard_load_seq_if.sv - source stream, control and table-load bus for plugboard_load_seq
//
// Purpose: groups the control, source stream and table-load signals of the
//   plugboard load sequencer.
// Signals:
//   start, abort           control from the configuration source
//   src_valid, src_data    source code stream, src_ready back to the source
//   table_idx, load,       table-load bus to the plugboard shift register
//   code_out
//   busy, done, count      sequencer status
// Modports:
//   master  configuration source side (drives control and stream)
//   slave   sequencer side (drives src_ready, load bus and status)

interface plugboard_load_seq_if #(
  parameter int CODE_W = 6
);
  logic              start;
  logic              abort;
  logic              src_valid;
  logic [CODE_W-1:0] src_data;
  logic              src_ready;
  logic [1:0]        table_idx;
  logic              load;
  logic [CODE_W-1:0] code_out;
  logic              busy;
  logic              done;
  logic [5:0]        count;

  modport master (
    output start, abort, src_valid, src_data,
    input  src_ready, table_idx, load, code_out, busy, done, count
  );

  modport slave (
    input  start, abort, src_valid, src_data,
    output src_ready, table_idx, load, code_out, busy, done, count
  );
endinterface

// File: rtl/plugboard_load_seq.sv
// rtl/plugboard_load_seq.sv - source-side sequencer issuing plugboard table-load strobes
//
// Purpose: on start, accepts exactly ENTRIES codes from a valid/ready stream
//   and issues each one as a single-cycle load strobe tagged with TABLE_IDX.
//   Entry 0 must be supplied first so it lands in slot 0 after the last shift.
// Parameters:
//   ENTRIES    codes per load sequence (2..63)
//   CODE_W     code width
//   TABLE_IDX  table index driven alongside every load strobe
// Ports:
//   i_clk      clock
//   i_rst_n    synchronous active-low reset
//   bus        plugboard_load_seq_if.slave
//                start/abort      sequence control (abort wins)
//                src_*            source stream; src_ready decoded from state
//                table_idx/load/  registered load bus; table_idx is 2'b11
//                code_out         when no strobe, code_out holds
//                busy/done/count  registered status

module plugboard_load_seq #(
  parameter int         ENTRIES   = 32,
  parameter int         CODE_W    = 6,
  parameter logic [1:0] TABLE_IDX = 2'b10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  plugboard_load_seq_if.slave   bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  localparam logic [5:0] LAST_COUNT = 6'(ENTRIES - 1);

  state_t            r_state;
  logic              r_load;
  logic [CODE_W-1:0] r_code;
  logic [1:0]        r_table_idx;
  logic              r_busy;
  logic              r_done;
  logic [5:0]        r_count;

  // Ready is a pure state decode so it never combinationally depends on
  // src_valid; the source may wait for ready before raising valid.
  logic w_ready;
  assign w_ready = (r_state == S_LOAD);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_load      <= 1'b0;
      r_code      <= '0;
      r_table_idx <= 2'b11;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
    end else begin
      // Strobe-type outputs default to their idle values every cycle.
      r_load      <= 1'b0;
      r_table_idx <= 2'b11;
      r_done      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_count <= '0;
          end
        end

        S_LOAD: begin
          if (bus.abort) begin
            // Cancel without accepting this cycle's transfer; count keeps
            // the partial value for the host to inspect.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.src_valid) begin
            r_load      <= 1'b1;
            r_code      <= bus.src_data;
            r_table_idx <= TABLE_IDX;
            r_count     <= r_count + 6'd1;
            if (r_count == LAST_COUNT) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.src_ready = w_ready;
  assign bus.table_idx = r_table_idx;
  assign bus.load      = r_load;
  assign bus.code_out  = r_code;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_plugboard_load_seq.sv
// tb/tb_plugboard_load_seq.sv - directed self-checking bench for plugboard_load_seq

module tb_plugboard_load_seq;

  localparam int CODE_W = 6;
  localparam int N      = 32;

  logic clk;
  logic rst_n;

  plugboard_load_seq_if #(.CODE_W(CODE_W)) bus ();

  plugboard_load_seq #(
    .ENTRIES   (N),
    .CODE_W    (CODE_W),
    .TABLE_IDX (2'b10)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Bench-side observation of the load bus
  logic [CODE_W-1:0] codes_q[$];
  logic [CODE_W-1:0] slots[N];
  int                load_cnt;
  int                done_cnt;
  logic              acc_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample at the falling edge: load must mirror the previous cycle's accept
  // as seen by the bench, table_idx must be 2 only during a strobe.
  task automatic monitor();
    check("load_follows_accept", bus.load, acc_prev);
    check("table_idx", bus.table_idx, bus.load ? 32'd2 : 32'd3);
    if (bus.load === 1'b1) begin
      codes_q.push_back(bus.code_out);
      for (int k = 0; k < N - 1; k++) slots[k] = slots[k + 1];
      slots[N - 1] = bus.code_out;
      load_cnt++;
    end
    if (bus.done === 1'b1) done_cnt++;
    acc_prev = rst_n && bus.src_valid && bus.src_ready && !bus.abort;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_ready", bus.src_ready, 1);
    check("start_count", bus.count, 0);
  endtask

  // Feed n codes first, first+step, ...; optional 1..3 cycle valid gaps.
  task automatic feed(input int n, input int first, input int step, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bus.src_valid = 1'b1;
      bus.src_data  = CODE_W'(first + step * i);
      tick();
      bus.src_valid = 1'b0;
      if (gaps && i < n - 1) repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  // Checks for the cycle after the final accept.
  task automatic check_final(input int last_code);
    check("fin_done", bus.done, 1);
    check("fin_load", bus.load, 1);
    check("fin_code", bus.code_out, last_code);
    check("fin_busy", bus.busy, 0);
    check("fin_ready", bus.src_ready, 0);
    check("fin_count", bus.count, N);
  endtask

  int base_l;
  int base_d;
  int base_q;
  int mism;

  initial begin
    n_checks = 0;
    n_errors = 0;
    load_cnt = 0;
    done_cnt = 0;
    acc_prev = 1'b0;
    for (int k = 0; k < N; k++) slots[k] = '0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    tick();
    tick();
    check("rst_ready", bus.src_ready, 0);
    check("rst_load", bus.load, 0);
    check("rst_code", bus.code_out, 0);
    check("rst_tidx", bus.table_idx, 3);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_count", bus.count, 0);
    rst_n = 1'b1;
    tick();

    // Back-to-back full load, 0..31
    base_l = load_cnt; base_d = done_cnt; base_q = codes_q.size();
    do_start();
    feed(N, 0, 1, 1'b0);
    check_final(N - 1);
    tick();
    check("b2b_done_clear", bus.done, 0);
    check("b2b_loads", load_cnt - base_l, N);
    check("b2b_dones", done_cnt - base_d, 1);
    mism = 0;
    for (int k = 0; k < N; k++) begin
      if (codes_q[base_q + k] !== CODE_W'(k)) mism++;
      if (slots[k] !== CODE_W'(k)) mism++;
    end
    check("b2b_order_slots", mism, 0);

    // Throttled source, 31..0
    base_l = load_cnt; base_d = done_cnt;
    do_start();
    feed(N, N - 1, -1, 1'b1);
    check_final(0);
    tick();
    tick();
    check("thr_loads", load_cnt - base_l, N);
    check("thr_dones", done_cnt - base_d, 1);
    mism = 0;
    for (int k = 0; k < N; k++) if (slots[k] !== CODE_W'(N - 1 - k)) mism++;
    check("thr_slots_reversed", mism, 0);

    // Abort on what would be the 10th accept
    base_l = load_cnt; base_d = done_cnt;
    do_start();
    feed(9, 0, 1, 1'b0);
    bus.src_valid = 1'b1;
    bus.src_data  = 6'd9;
    bus.abort     = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.src_valid = 1'b0;
    check("abt_load", bus.load, 0);
    check("abt_done", bus.done, 0);
    check("abt_count", bus.count, 9);
    check("abt_busy", bus.busy, 0);
    check("abt_ready", bus.src_ready, 0);
    tick();
    check("abt_loads", load_cnt - base_l, 9);
    check("abt_dones", done_cnt - base_d, 0);
    do_start();
    feed(N, 0, 1, 1'b0);
    check_final(N - 1);
    tick();

    // Reset mid-operation with a pending strobe
    base_l = load_cnt;
    do_start();
    feed(5, 0, 1, 1'b0);
    rst_n         = 1'b0;
    bus.src_valid = 1'b1;
    bus.src_data  = 6'd5;
    tick();
    rst_n = 1'b1;
    check("mrst_load", bus.load, 0);
    check("mrst_code", bus.code_out, 0);
    check("mrst_tidx", bus.table_idx, 3);
    check("mrst_busy", bus.busy, 0);
    check("mrst_ready", bus.src_ready, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_count", bus.count, 0);
    repeat (3) tick();
    bus.src_valid = 1'b0;
    check("mrst_idle_busy", bus.busy, 0);
    check("mrst_idle_count", bus.count, 0);
    check("mrst_loads", load_cnt - base_l, 5);

    // Protocol edges: start+abort in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_busy", bus.busy, 0);
    check("sa_ready", bus.src_ready, 0);

    // start while busy: no restart, no count clear
    do_start();
    feed(3, 0, 1, 1'b0);
    bus.start = 1'b1;
    feed(1, 3, 1, 1'b0);
    bus.start = 1'b0;
    check("sb_count", bus.count, 4);
    check("sb_busy", bus.busy, 1);
    feed(N - 4, 4, 1, 1'b0);
    check_final(N - 1);

    // start in the done cycle re-enters LOAD with count cleared
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rs_busy", bus.busy, 1);
    check("rs_ready", bus.src_ready, 1);
    check("rs_count", bus.count, 0);
    check("rs_done", bus.done, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
    check("rs_abort_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
